// File: rtl/risc16_mem_arbiter.sv
// risc16_mem_arbiter
// Shares the single RiSC16 memory port between two requesters. Requester 0 is
// instruction fetch (read-only). Requester 1 is load/store (read/write).
// Each access is a req/ack handshake and runs through IDLE -> ACCESS -> DONE.
// When both requesters ask at once, a round-robin pointer decides the winner.
//
// Ports:
//   clk, rst                 clock; asynchronous active-high reset
//   req0/addr0               fetch request and address
//   ack0/rdata0              fetch completion pulse and the fetched word
//   req1/we1/addr1/wdata1    load/store request, direction, address and data
//   ack1/rdata1              load/store completion pulse and load data
//                            (a store echoes its write data here)
//   gnt0/gnt1                high while the requester owns the memory
//   memAddress/memDataIn/memWriteEn   drive the memory pins
//   memDataOut               asynchronous read data from memory
module risc16_mem_arbiter #(
    parameter int WORD_LENGTH = 16,
    parameter int ADDR_WIDTH  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req0,
    input  logic [ADDR_WIDTH-1:0]  addr0,
    output logic                   ack0,
    output logic [WORD_LENGTH-1:0] rdata0,
    input  logic                   req1,
    input  logic                   we1,
    input  logic [ADDR_WIDTH-1:0]  addr1,
    input  logic [WORD_LENGTH-1:0] wdata1,
    output logic                   ack1,
    output logic [WORD_LENGTH-1:0] rdata1,
    output logic                   gnt0,
    output logic                   gnt1,
    output logic [ADDR_WIDTH-1:0]  memAddress,
    output logic [WORD_LENGTH-1:0] memDataIn,
    output logic                   memWriteEn,
    input  logic [WORD_LENGTH-1:0] memDataOut
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t state;
    logic   last;    // requester granted most recently
    logic   owner;   // requester owning the transaction in flight
    logic   pick1;   // requester 1 wins the current IDLE arbitration

    // A lone request always wins. On a tie, the requester not granted last wins.
    assign pick1 = req1 & (~req0 | ~last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last       <= 1'b1;
            owner      <= 1'b0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            gnt0       <= 1'b0;
            gnt1       <= 1'b0;
            rdata0     <= '0;
            rdata1     <= '0;
            memAddress <= '0;
            memDataIn  <= '0;
            memWriteEn <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        owner <= pick1;
                        last  <= pick1;
                        gnt0  <= ~pick1;
                        gnt1  <= pick1;
                        if (pick1) begin
                            memAddress <= addr1;
                            memDataIn  <= wdata1;
                            memWriteEn <= we1;
                        end else begin
                            // memDataIn keeps its old value on a fetch.
                            memAddress <= addr0;
                            memWriteEn <= 1'b0;
                        end
                        state <= ACCESS;
                    end
                end
                ACCESS: begin
                    // Memory pins have been stable for the whole cycle. A store
                    // commits at this edge, and a read is captured at this edge.
                    if (owner) begin
                        rdata1 <= memWriteEn ? memDataIn : memDataOut;
                        ack1   <= 1'b1;
                    end else begin
                        rdata0 <= memDataOut;
                        ack0   <= 1'b1;
                    end
                    memWriteEn <= 1'b0;
                    state      <= DONE;
                end
                DONE: begin
                    // The request is ignored here, so a held req cannot
                    // retrigger before the requester has seen its ack.
                    ack0  <= 1'b0;
                    ack1  <= 1'b0;
                    gnt0  <= 1'b0;
                    gnt1  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_risc16_mem_arbiter.sv
// Testbench for risc16_mem_arbiter. It includes a behavioural memory with
// asynchronous read and synchronous write. Expected completions go into a
// scoreboard queue when stimulus is driven, and a monitor pops them when an
// ack appears. Directed checks cover timing, boundaries and reset behaviour.
module tb_risc16_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [15:0] addr0 = '0, addr1 = '0, wdata1 = '0;
    logic        ack0, ack1, gnt0, gnt1, memWriteEn;
    logic [15:0] rdata0, rdata1, memAddress, memDataIn, memDataOut;

    logic [15:0] mem [0:65535];

    typedef struct {
        logic        port;
        logic [15:0] data;
    } exp_t;
    exp_t sb[$];

    int n_cmp = 0;
    int n_err = 0;

    risc16_mem_arbiter #(.WORD_LENGTH(16), .ADDR_WIDTH(16)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .addr0(addr0), .ack0(ack0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .ack1(ack1), .rdata1(rdata1),
        .gnt0(gnt0), .gnt1(gnt1),
        .memAddress(memAddress), .memDataIn(memDataIn),
        .memWriteEn(memWriteEn), .memDataOut(memDataOut)
    );

    always #5 clk = ~clk;

    assign memDataOut = mem[memAddress];
    always @(posedge clk) if (memWriteEn) mem[memAddress] <= memDataIn;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic push(input logic port, input logic [15:0] data);
        exp_t e;
        e.port = port;
        e.data = data;
        sb.push_back(e);
    endtask

    // Scoreboard monitor: every ack must match the next expected completion.
    always @(negedge clk) begin
        if (!rst && (ack0 || ack1)) begin
            if (sb.size() == 0) begin
                chk("unexpected_ack", {30'd0, ack1, ack0}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("ack_port", {31'd0, ack1}, {31'd0, e.port});
                chk("ack_single", {31'd0, ack0 & ack1}, 32'd0);
                chk("rdata", {16'd0, (e.port ? rdata1 : rdata0)}, {16'd0, e.data});
            end
        end
    end

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 16'(i ^ 16'h5A5A);
        mem[16'h1222] = 16'hBEEF;
        mem[16'h0100] = 16'hA1A1;
        mem[16'h0200] = 16'hB2B2;
        mem[16'h0010] = 16'h1010;
        mem[16'h0020] = 16'h2020;

        // Check the reset state.
        step(); step();
        chk("rst_ack", {30'd0, ack1, ack0}, 32'd0);
        chk("rst_gnt", {30'd0, gnt1, gnt0}, 32'd0);
        chk("rst_we", {31'd0, memWriteEn}, 32'd0);
        chk("rst_addr", {16'd0, memAddress}, 32'd0);
        chk("rst_din", {16'd0, memDataIn}, 32'd0);
        chk("rst_rdata", {rdata1, rdata0}, 32'd0);
        rst = 1'b0;

        // Fetch from 0x1222.
        req0 = 1'b1; addr0 = 16'h1222; push(1'b0, 16'hBEEF);
        step();
        chk("f_gnt0", {30'd0, gnt1, gnt0}, 32'd1);
        chk("f_ack_early", {31'd0, ack0}, 32'd0);
        chk("f_we_acc", {31'd0, memWriteEn}, 32'd0);
        chk("f_addr", {16'd0, memAddress}, 32'h1222);
        step();
        chk("f_ack0", {31'd0, ack0}, 32'd1);
        chk("f_we_done", {31'd0, memWriteEn}, 32'd0);
        req0 = 1'b0;
        step();
        chk("f_ack_end", {31'd0, ack0}, 32'd0);
        chk("f_gnt_end", {30'd0, gnt1, gnt0}, 32'd0);

        // Store 0x2000 to 0x1222, then load it back.
        req1 = 1'b1; we1 = 1'b1; addr1 = 16'h1222; wdata1 = 16'h2000;
        push(1'b1, 16'h2000);
        step();
        chk("s_we", {31'd0, memWriteEn}, 32'd1);
        chk("s_addr", {16'd0, memAddress}, 32'h1222);
        chk("s_din", {16'd0, memDataIn}, 32'h2000);
        chk("s_gnt1", {30'd0, gnt1, gnt0}, 32'd2);
        step();
        chk("s_we_off", {31'd0, memWriteEn}, 32'd0);
        chk("s_ack1", {31'd0, ack1}, 32'd1);
        req1 = 1'b0; we1 = 1'b0;
        step();
        chk("s_mem", {16'd0, mem[16'h1222]}, 32'h2000);
        req1 = 1'b1; we1 = 1'b0; wdata1 = 16'hFFFF;
        push(1'b1, 16'h2000);
        step();
        chk("l_we", {31'd0, memWriteEn}, 32'd0);
        step();
        chk("l_ack1", {31'd0, ack1}, 32'd1);
        chk("l_rdata0_kept", {16'd0, rdata0}, 32'hBEEF);
        req1 = 1'b0;
        step();

        // Simultaneous requests right after a reset. Expect acks 0,1,0,1 every 3 cycles.
        rst = 1'b1; step(); rst = 1'b0;
        req0 = 1'b1; addr0 = 16'h0100;
        req1 = 1'b1; addr1 = 16'h0200; we1 = 1'b0;
        push(1'b0, 16'hA1A1); push(1'b1, 16'hB2B2);
        push(1'b0, 16'hA1A1); push(1'b1, 16'hB2B2);
        for (int k = 0; k < 12; k++) begin
            step();
            chk($sformatf("rr_ack0_k%0d", k), {31'd0, ack0}, {31'd0, (k == 1 || k == 7)});
            chk($sformatf("rr_ack1_k%0d", k), {31'd0, ack1}, {31'd0, (k == 4 || k == 10)});
        end
        req0 = 1'b0; req1 = 1'b0;
        step();

        // Change the address while the load is in ACCESS. The latched address must win.
        req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0010;
        push(1'b1, 16'h1010);
        step();
        addr1 = 16'h0020;
        #1 chk("mid_addr", {16'd0, memAddress}, 32'h0010);
        step();
        chk("mid_ack1", {31'd0, ack1}, 32'd1);
        req1 = 1'b0;
        step();

        // Assert reset during ACCESS of a store. The access must abort, then restart.
        req1 = 1'b1; we1 = 1'b1; addr1 = 16'h0005; wdata1 = 16'hABCD;
        step();
        chk("ar_we_pre", {31'd0, memWriteEn}, 32'd1);
        rst = 1'b1;
        #1;
        chk("ar_we", {31'd0, memWriteEn}, 32'd0);
        chk("ar_ack", {30'd0, ack1, ack0}, 32'd0);
        chk("ar_gnt", {30'd0, gnt1, gnt0}, 32'd0);
        chk("ar_addr", {16'd0, memAddress}, 32'd0);
        chk("ar_din", {16'd0, memDataIn}, 32'd0);
        chk("ar_rdata", {rdata1, rdata0}, 32'd0);
        step();
        chk("ar_no_ack", {30'd0, ack1, ack0}, 32'd0);
        rst = 1'b0;
        push(1'b1, 16'hABCD);
        step();
        chk("ar_re_we", {31'd0, memWriteEn}, 32'd1);
        chk("ar_re_addr", {16'd0, memAddress}, 32'h0005);
        step();
        chk("ar_re_ack1", {31'd0, ack1}, 32'd1);
        req1 = 1'b0; we1 = 1'b0;
        step();
        chk("ar_mem", {16'd0, mem[16'h0005]}, 32'hABCD);

        step(); step();
        chk("sb_empty", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/risc16_mem_arbiter.md
# risc16_mem_arbiter

Two-requester arbiter and access sequencer for the single-port RiSC16 main memory (WORD_LENGTH 16, 65536 words). It shares the one memory port between the instruction-fetch unit (requester 0, read-only) and the load/store unit (requester 1, read/write). It uses a req/ack handshake, round-robin priority and a fixed three-state access sequence. It sits between the core datapath and the memory's address/dataIn/writeEn/dataOut pins.

## Interface
Parameters:
- WORD_LENGTH, 16, data word width
- ADDR_WIDTH, 16, address width

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  reset; one clock; reset is asynchronous and active-high
- req0  in  1  fetch request; held high until ack0
- addr0  in  ADDR_WIDTH  fetch address
- ack0  out  1  one-cycle pulse; fetch complete, rdata0 valid
- rdata0  out  WORD_LENGTH  fetched word, held until next requester-0 ack
- req1  in  1  load/store request; held high until ack1
- we1  in  1  1 = store, 0 = load
- addr1  in  ADDR_WIDTH  load/store address
- wdata1  in  WORD_LENGTH  store data
- ack1  out  1  one-cycle pulse; load/store complete
- rdata1  out  WORD_LENGTH  load data (store: echoes wdata1), held until next requester-1 ack
- gnt0, gnt1  out  1  high while the respective requester owns the memory (ACCESS and DONE)
- memAddress  out  ADDR_WIDTH  to memory address
- memDataIn  out  WORD_LENGTH  to memory dataIn
- memWriteEn  out  1  to memory writeEn
- memDataOut  in  WORD_LENGTH  from memory dataOut

## Operation
- Memory contract: read is asynchronous (memDataOut follows memAddress within the cycle). A write commits on the rising edge while writeEn is high.
- FSM states: IDLE, ACCESS, DONE.
- IDLE: if neither req is high, stay. Otherwise select a winner, latch its addr into memAddress, wdata1 into memDataIn (requester 1 only), and set memWriteEn = we1 (requester 1) or 0 (requester 0). Set the winner's gnt, then go to ACCESS.
- Arbitration is round-robin on a 1-bit last-grant pointer. With one request, grant it. With both, grant the requester not granted last. The pointer updates on every grant.
- ACCESS (exactly one cycle): memory outputs are stable. At the closing edge:
  - capture memDataOut (load/fetch) or the latched write data (store) into the winner's rdata;
  - clear memWriteEn;
  - assert the winner's ack;
  - go to DONE.
- DONE (one cycle): ack high. The winner's req is ignored this cycle. At the closing edge, clear ack and gnt and go to IDLE.
- A req still high in IDLE after its ack is a new request.
- memAddress and memDataIn hold their last value while idle. memWriteEn is high only in ACCESS.
- The loser's rdata and ack are untouched.
- addr/wdata/we changes after the IDLE sampling edge do not affect the transaction in flight.

## Timing
- Reset (async, immediate) values:
  - state IDLE, pointer = 1 (requester 0 wins the first tie);
  - ack0 = ack1 = 0, gnt0 = gnt1 = 0;
  - memWriteEn = 0, memAddress = 0, memDataIn = 0;
  - rdata0 = rdata1 = 0.
- Latency: req sampled high at edge E (state IDLE) → ACCESS during cycle E..E+1 → ack high during cycle E+1..E+2. The store commits to memory at edge E+1.
- Throughput: one transaction per 3 cycles. Under continuous dual requests, grants alternate 0,1,0,1, so neither requester waits more than one transaction.
- Reset asserted in ACCESS aborts the access: memWriteEn drops immediately, no ack is issued, and a store in progress is not guaranteed committed. After release, pending requests re-arbitrate from IDLE with pointer = 1.
- Reset asserted in DONE: ack drops immediately, and rdata returns to 0.

## Test plan
- Reset, then req0 with addr0=16'h1222 (memory preloaded 16'hBEEF) → gnt0 one cycle later, ack0 pulse exactly 2 cycles after sampling, rdata0=16'hBEEF, memWriteEn never high.
- Store then load: req1/we1=1, addr1=16'h1222, wdata1=16'h2000 → memWriteEn high for exactly one cycle with memAddress=16'h1222, memDataIn=16'h2000. Then a load from 16'h1222 → rdata1=16'h2000.
- Simultaneous req0 and req1 first after reset → requester 0 granted first, then requester 1. Both held high for 12 cycles → ack order 0,1,0,1, one ack every 3 cycles.
- Request input changed mid-transaction: addr1 changed from 16'h0010 to 16'h0020 during ACCESS → memAddress stays 16'h0010, and the load returns the word at 16'h0010.
- Reset asserted during ACCESS of a store to 16'h0005 → memWriteEn low within the same cycle, no ack1, all outputs at reset values. After release with req1 still high → the transaction restarts and completes normally.
